// File: rtl/slice_controller.sv
// Slicing job sequencer: calibrate, feed and cut N slices, then return to the start position.
// Outputs are registered decodes of the next state, so every output follows its qualifying input by one clock.
module slice_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        pause,
  input  logic [4:0]  slice_num,
  input  logic        valid,
  input  logic [16:0] distance,
  input  logic        triggerSuc,
  output logic        trigger,
  output logic        move,
  input  logic        cut_end,
  output logic        cut,
  output logic        finish,
  output logic        back
);

  typedef enum logic [3:0] {
    IDLE, CAL_TRIG, CAL_WAIT, TRIG, WAIT, CUT, BTRIG, BWAIT, PAUSE, DONE
  } state_t;

  typedef enum logic [1:0] {PH_CAL, PH_FEED, PH_BACK} phase_t;

  state_t      state_q, state_d;
  phase_t      phase_q, phase_d;
  logic [4:0]  k_q, k_d;
  logic [4:0]  sn_q, sn_d;
  logic [16:0] l0_q, l0_d;
  logic        trigger_q, trigger_d;
  logic        move_q, move_d;
  logic        cut_q, cut_d;
  logic        finish_q, finish_d;
  logic        back_q, back_d;

  logic [21:0] feed_lhs, feed_rhs;
  logic [4:0]  k_inc;

  // Cut point for slice k: distance/L0 <= (N-1-k)/N, cross-multiplied to stay in integers.
  assign feed_lhs = 22'(distance) * 22'(sn_q);
  assign feed_rhs = 22'(l0_q) * 22'(5'(sn_q - 5'd1 - k_q));
  assign k_inc    = k_q + 5'd1;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    k_d     = k_q;
    sn_d    = sn_q;
    l0_d    = l0_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = CAL_TRIG;
          k_d     = 5'd0;
          sn_d    = slice_num;
        end
      end
      CAL_TRIG: begin
        if (pause) begin
          state_d = PAUSE;
          phase_d = PH_CAL;
        end else if (triggerSuc) begin
          state_d = CAL_WAIT;
        end
      end
      CAL_WAIT: begin
        if (pause) begin
          state_d = PAUSE;
          phase_d = PH_CAL;
        end else if (valid) begin
          l0_d    = distance;
          state_d = (sn_q < 5'd2) ? DONE : TRIG;
        end
      end
      TRIG: begin
        if (pause) begin
          state_d = PAUSE;
          phase_d = PH_FEED;
        end else if (triggerSuc) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (pause) begin
          state_d = PAUSE;
          phase_d = PH_FEED;
        end else if (valid) begin
          state_d = (feed_lhs <= feed_rhs) ? CUT : TRIG;
        end
      end
      CUT: begin
        if (cut_end) begin
          k_d     = k_inc;
          state_d = (k_inc == 5'(sn_q - 5'd1)) ? BTRIG : TRIG;
        end
      end
      BTRIG: begin
        if (pause) begin
          state_d = PAUSE;
          phase_d = PH_BACK;
        end else if (triggerSuc) begin
          state_d = BWAIT;
        end
      end
      BWAIT: begin
        if (pause) begin
          state_d = PAUSE;
          phase_d = PH_BACK;
        end else if (valid) begin
          state_d = (distance >= l0_q) ? DONE : BTRIG;
        end
      end
      PAUSE: begin
        // Resume re-issues the trigger; any measurement in flight is dropped.
        if (pause) begin
          case (phase_q)
            PH_CAL:  state_d = CAL_TRIG;
            PH_FEED: state_d = TRIG;
            default: state_d = BTRIG;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    trigger_d = 1'b0;
    move_d    = 1'b0;
    cut_d     = 1'b0;
    finish_d  = 1'b0;
    back_d    = 1'b0;
    case (state_d)
      CAL_TRIG: trigger_d = 1'b1;
      TRIG: begin
        trigger_d = 1'b1;
        move_d    = 1'b1;
      end
      WAIT:     move_d = 1'b1;
      CUT:      cut_d = 1'b1;
      BTRIG: begin
        trigger_d = 1'b1;
        back_d    = 1'b1;
      end
      BWAIT:    back_d = 1'b1;
      DONE:     finish_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      phase_q   <= PH_CAL;
      k_q       <= 5'd0;
      sn_q      <= 5'd0;
      l0_q      <= 17'd0;
      trigger_q <= 1'b0;
      move_q    <= 1'b0;
      cut_q     <= 1'b0;
      finish_q  <= 1'b0;
      back_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      k_q       <= k_d;
      sn_q      <= sn_d;
      l0_q      <= l0_d;
      trigger_q <= trigger_d;
      move_q    <= move_d;
      cut_q     <= cut_d;
      finish_q  <= finish_d;
      back_q    <= back_d;
    end
  end

  assign trigger = trigger_q;
  assign move    = move_q;
  assign cut     = cut_q;
  assign finish  = finish_q;
  assign back    = back_q;

endmodule

// File: tb/tb_slice_controller.sv
// Scenario bench for slice_controller: each step's expected {trigger,move,cut,finish,back}
// is queued when stimulus is driven and popped when the following clock edge has settled.
module tb_slice_controller;

  logic        clk = 1'b0;
  logic        rst, start, pause, valid, triggerSuc, cut_end;
  logic [4:0]  slice_num;
  logic [16:0] distance;
  logic        trigger, move, cut, finish, back;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        r, st, pa, ts, va;
    logic [16:0] d;
    logic        ce;
    logic [4:0]  e;
  } step_t;

  logic [4:0] exp_q[$];
  logic [4:0] exp_v, obs_v;

  slice_controller dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .slice_num(slice_num),
    .valid(valid), .distance(distance), .triggerSuc(triggerSuc), .trigger(trigger),
    .move(move), .cut_end(cut_end), .cut(cut), .finish(finish), .back(back)
  );

  always #5 clk = ~clk;

  // Expected output encodings {trigger,move,cut,finish,back}
  localparam logic [4:0] O_NONE = 5'b00000, O_CTRIG = 5'b10000, O_TRIG = 5'b11000,
                         O_WAIT = 5'b01000, O_CUT = 5'b00100, O_DONE = 5'b00010,
                         O_BTRIG = 5'b10001, O_BWAIT = 5'b00001;

  function automatic step_t s(logic r, logic st, logic pa, logic ts, logic va,
                              logic [16:0] d, logic ce, logic [4:0] e);
    step_t x;
    x.r = r; x.st = st; x.pa = pa; x.ts = ts; x.va = va; x.d = d; x.ce = ce; x.e = e;
    return x;
  endfunction

  task automatic test_reset();
    step_t tbl[$];
    tbl.push_back(s(1, 0, 0, 0, 0, 0, 0, O_NONE));
    tbl.push_back(s(1, 1, 0, 1, 1, 17'd5, 1, O_NONE));
    tbl.push_back(s(0, 0, 0, 0, 0, 0, 0, O_NONE));
    tbl.push_back(s(0, 0, 1, 0, 0, 0, 0, O_NONE));
    tbl.push_back(s(0, 0, 0, 1, 1, 17'd100, 0, O_NONE));
    tbl.push_back(s(0, 0, 0, 0, 0, 0, 1, O_NONE));
    foreach (tbl[i]) begin
      rst = tbl[i].r; start = tbl[i].st; pause = tbl[i].pa; triggerSuc = tbl[i].ts;
      valid = tbl[i].va; distance = tbl[i].d; cut_end = tbl[i].ce;
      exp_q.push_back(tbl[i].e);
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      obs_v = {trigger, move, cut, finish, back};
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL reset step %0d: got %b want %b", i, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_full_job();
    step_t tbl[$];
    slice_num = 5'd4;
    tbl.push_back(s(0, 1, 0, 0, 0, 0, 0, O_CTRIG));
    tbl.push_back(s(0, 0, 0, 0, 1, 17'd50, 0, O_CTRIG));   // valid outside WAIT ignored
    tbl.push_back(s(0, 0, 0, 1, 0, 0, 0, O_NONE));
    tbl.push_back(s(0, 0, 0, 0, 1, 17'd900, 0, O_TRIG));
    tbl.push_back(s(0, 1, 0, 0, 0, 0, 0, O_TRIG));          // start ignored mid-job
    tbl.push_back(s(0, 0, 0, 1, 0, 0, 0, O_WAIT));
    tbl.push_back(s(0, 0, 0, 1, 0, 0, 0, O_WAIT));          // triggerSuc ignored in WAIT
    tbl.push_back(s(0, 0, 0, 0, 1, 17'd600, 0, O_CUT));
    tbl.push_back(s(0, 0, 1, 0, 0, 0, 0, O_CUT));           // pause ignored in CUT
    tbl.push_back(s(0, 0, 0, 0, 0, 0, 1, O_TRIG));
    tbl.push_back(s(0, 0, 0, 1, 0, 0, 0, O_WAIT));
    tbl.push_back(s(0, 0, 0, 0, 1, 17'd500, 0, O_TRIG));
    tbl.push_back(s(0, 0, 0, 1, 0, 0, 0, O_WAIT));
    tbl.push_back(s(0, 0, 0, 0, 1, 17'd350, 0, O_CUT));
    tbl.push_back(s(0, 0, 0, 0, 0, 0, 1, O_TRIG));
    tbl.push_back(s(0, 0, 0, 1, 0, 0, 0, O_WAIT));
    tbl.push_back(s(0, 0, 0, 0, 1, 17'd200, 0, O_CUT));
    tbl.push_back(s(0, 0, 0, 0, 0, 0, 1, O_BTRIG));
    tbl.push_back(s(0, 0, 0, 1, 0, 0, 0, O_BWAIT));
    tbl.push_back(s(0, 0, 0, 0, 1, 17'd500, 0, O_BTRIG));
    tbl.push_back(s(0, 0, 0, 1, 0, 0, 0, O_BWAIT));
    tbl.push_back(s(0, 0, 0, 0, 1, 17'd740, 0, O_BTRIG));
    tbl.push_back(s(0, 0, 0, 1, 0, 0, 0, O_BWAIT));
    tbl.push_back(s(0, 0, 0, 0, 1, 17'd910, 0, O_DONE));
    tbl.push_back(s(0, 0, 1, 1, 1, 17'd1, 1, O_DONE));
    foreach (tbl[i]) begin
      rst = tbl[i].r; start = tbl[i].st; pause = tbl[i].pa; triggerSuc = tbl[i].ts;
      valid = tbl[i].va; distance = tbl[i].d; cut_end = tbl[i].ce;
      if (i == 1) slice_num = 5'd9;  // must have been captured at start
      exp_q.push_back(tbl[i].e);
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      obs_v = {trigger, move, cut, finish, back};
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL full_job step %0d: got %b want %b", i, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_pause();
    step_t tbl[$];
    slice_num = 5'd4;
    tbl.push_back(s(0, 1, 0, 0, 0, 0, 0, O_CTRIG));
    tbl.push_back(s(0, 0, 0, 1, 0, 0, 0, O_NONE));
    tbl.push_back(s(0, 0, 0, 0, 1, 17'd900, 0, O_TRIG));
    tbl.push_back(s(0, 0, 1, 0, 0, 0, 0, O_NONE));
    tbl.push_back(s(0, 0, 0, 0, 0, 0, 0, O_NONE));
    tbl.push_back(s(0, 0, 0, 1, 1, 17'd10, 0, O_NONE));
    tbl.push_back(s(0, 0, 1, 0, 0, 0, 0, O_TRIG));
    tbl.push_back(s(0, 0, 0, 1, 0, 0, 0, O_WAIT));
    tbl.push_back(s(0, 0, 1, 0, 1, 17'd100, 0, O_NONE));   // pause beats valid
    tbl.push_back(s(0, 0, 1, 0, 0, 0, 0, O_TRIG));
    tbl.push_back(s(0, 0, 1, 1, 0, 0, 0, O_NONE));         // pause beats triggerSuc
    tbl.push_back(s(0, 0, 1, 0, 0, 0, 0, O_TRIG));
    tbl.push_back(s(0, 0, 0, 1, 0, 0, 0, O_WAIT));
    tbl.push_back(s(0, 0, 0, 0, 1, 17'd600, 0, O_CUT));
    foreach (tbl[i]) begin
      rst = tbl[i].r; start = tbl[i].st; pause = tbl[i].pa; triggerSuc = tbl[i].ts;
      valid = tbl[i].va; distance = tbl[i].d; cut_end = tbl[i].ce;
      exp_q.push_back(tbl[i].e);
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      obs_v = {trigger, move, cut, finish, back};
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL pause step %0d: got %b want %b", i, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_reset_midjob();
    step_t tbl[$];
    tbl.push_back(s(1, 0, 0, 0, 0, 0, 0, O_NONE));
    tbl.push_back(s(0, 0, 0, 0, 1, 17'd600, 0, O_NONE));
    tbl.push_back(s(0, 0, 0, 1, 0, 0, 0, O_NONE));
    tbl.push_back(s(0, 0, 0, 0, 0, 0, 1, O_NONE));
    tbl.push_back(s(0, 0, 1, 0, 0, 0, 0, O_NONE));
    foreach (tbl[i]) begin
      rst = tbl[i].r; start = tbl[i].st; pause = tbl[i].pa; triggerSuc = tbl[i].ts;
      valid = tbl[i].va; distance = tbl[i].d; cut_end = tbl[i].ce;
      exp_q.push_back(tbl[i].e);
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      obs_v = {trigger, move, cut, finish, back};
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL reset_midjob step %0d: got %b want %b", i, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_slice_one();
    step_t tbl[$];
    slice_num = 5'd1;
    tbl.push_back(s(0, 1, 0, 0, 0, 0, 0, O_CTRIG));
    tbl.push_back(s(0, 0, 0, 1, 0, 0, 0, O_NONE));
    tbl.push_back(s(0, 0, 0, 0, 1, 17'd500, 0, O_DONE));
    tbl.push_back(s(0, 0, 0, 0, 0, 0, 0, O_DONE));
    foreach (tbl[i]) begin
      rst = tbl[i].r; start = tbl[i].st; pause = tbl[i].pa; triggerSuc = tbl[i].ts;
      valid = tbl[i].va; distance = tbl[i].d; cut_end = tbl[i].ce;
      exp_q.push_back(tbl[i].e);
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      obs_v = {trigger, move, cut, finish, back};
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL slice_one step %0d: got %b want %b", i, obs_v, exp_v);
      end
    end
  endtask

  // Two slices with the feed and return decisions landing exactly on their thresholds.
  task automatic test_back_to_back();
    step_t tbl[$];
    slice_num = 5'd2;
    tbl.push_back(s(0, 1, 0, 0, 0, 0, 0, O_CTRIG));
    tbl.push_back(s(0, 0, 0, 1, 0, 0, 0, O_NONE));
    tbl.push_back(s(0, 0, 0, 0, 1, 17'd1000, 0, O_TRIG));
    tbl.push_back(s(0, 0, 0, 1, 0, 0, 0, O_WAIT));
    tbl.push_back(s(0, 0, 0, 0, 1, 17'd501, 0, O_TRIG));
    tbl.push_back(s(0, 0, 0, 1, 0, 0, 0, O_WAIT));
    tbl.push_back(s(0, 0, 0, 0, 1, 17'd500, 0, O_CUT));
    tbl.push_back(s(0, 0, 0, 0, 0, 0, 1, O_BTRIG));
    tbl.push_back(s(0, 0, 1, 0, 0, 0, 0, O_NONE));
    tbl.push_back(s(0, 0, 1, 0, 0, 0, 0, O_BTRIG));
    tbl.push_back(s(0, 0, 0, 1, 0, 0, 0, O_BWAIT));
    tbl.push_back(s(0, 0, 0, 0, 1, 17'd999, 0, O_BTRIG));
    tbl.push_back(s(0, 0, 0, 1, 0, 0, 0, O_BWAIT));
    tbl.push_back(s(0, 0, 0, 0, 1, 17'd1000, 0, O_DONE));
    foreach (tbl[i]) begin
      rst = tbl[i].r; start = tbl[i].st; pause = tbl[i].pa; triggerSuc = tbl[i].ts;
      valid = tbl[i].va; distance = tbl[i].d; cut_end = tbl[i].ce;
      exp_q.push_back(tbl[i].e);
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      obs_v = {trigger, move, cut, finish, back};
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL back_to_back step %0d: got %b want %b", i, obs_v, exp_v);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0; valid = 1'b0; triggerSuc = 1'b0;
    cut_end = 1'b0; distance = 17'd0; slice_num = 5'd0;
    #1;
    test_reset();
    test_full_job();
    test_pause();
    test_reset_midjob();
    test_slice_one();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
